// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and defaults for the PF PC redirect controller.
package pc_redirect_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_VEC = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] DEF_EX_VEC    = 32'hBFC0_0380;

  // Encoding is ordered so that a numeric compare equals a priority compare.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_BR   = 2'd1,
    RD_ERET = 2'd2,
    RD_EX   = 2'd3
  } rd_src_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

endpackage

// File: rtl/pc_redirect_ctrl_prio_sel.sv
// Priority encode of live redirect sources and arbitration against a held redirect.
module rd_prio_sel
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] EX_VEC = DEF_EX_VEC
) (
  input  logic            br_req,
  input  logic [XLEN-1:0] br_target,
  input  logic            eret_req,
  input  logic [XLEN-1:0] epc,
  input  logic            ex_req,
  input  rd_src_t         pend_src,
  input  logic [XLEN-1:0] pend_tgt,
  output rd_src_t         live_src,
  output logic [XLEN-1:0] live_tgt,
  output logic [XLEN-1:0] eff_tgt,
  output logic            override
);

  // Live source: exception beats ERET beats branch.
  always_comb begin
    live_src = RD_NONE;
    live_tgt = '0;
    if (ex_req) begin
      live_src = RD_EX;
      live_tgt = EX_VEC;
    end else if (eret_req) begin
      live_src = RD_ERET;
      live_tgt = epc;
    end else if (br_req) begin
      live_src = RD_BR;
      live_tgt = br_target;
    end
  end

  // Live wins only when strictly higher; ties keep the older pending redirect.
  always_comb begin
    override = (live_src > pend_src);
    eff_tgt  = override ? live_tgt : pend_tgt;
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Pre-fetch PC register with redirect arbitration, hold-while-busy and flush strobes.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [XLEN-1:0] EX_VEC    = DEF_EX_VEC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_wr,
  input  logic            pf_ready,
  input  logic            br_req,
  input  logic [XLEN-1:0] br_target,
  input  logic            eret_req,
  input  logic [XLEN-1:0] epc,
  input  logic            ex_req,
  output logic [XLEN-1:0] pf_pc,
  output logic            front_flush,
  output logic            pf_flush,
  output logic            pf_cancel,
  output logic            rd_pending
);

  state_t          state;
  rd_src_t         pend_src;
  logic [XLEN-1:0] pend_tgt;
  rd_src_t         live_src;
  logic [XLEN-1:0] live_tgt;
  logic [XLEN-1:0] eff_tgt;
  logic            override;

  rd_prio_sel #(
    .EX_VEC (EX_VEC)
  ) u_prio_sel (
    .br_req    (br_req),
    .br_target (br_target),
    .eret_req  (eret_req),
    .epc       (epc),
    .ex_req    (ex_req),
    .pend_src  (pend_src),
    .pend_tgt  (pend_tgt),
    .live_src  (live_src),
    .live_tgt  (live_tgt),
    .eff_tgt   (eff_tgt),
    .override  (override)
  );

  // PC / pending-redirect FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pf_pc    <= RESET_VEC;
      pend_src <= RD_NONE;
      pend_tgt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (live_src != RD_NONE) begin
            if (pf_ready) begin
              pf_pc <= live_tgt;
            end else begin
              pend_src <= live_src;
              pend_tgt <= live_tgt;
              state    <= S_PEND;
            end
          end else if (pc_wr && pf_ready) begin
            pf_pc <= pf_pc + XLEN'(4);
          end
        end
        S_PEND: begin
          if (pf_ready) begin
            pf_pc    <= eff_tgt;
            pend_src <= RD_NONE;
            pend_tgt <= '0;
            state    <= S_IDLE;
          end else if (override) begin
            pend_src <= live_src;
            pend_tgt <= live_tgt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Flush / cancel strobes accompany the redirect in the same cycle.
  always_comb begin
    pf_flush  = 1'b0;
    pf_cancel = 1'b0;
    case (state)
      S_IDLE: begin
        if (live_src != RD_NONE) begin
          pf_flush  = 1'b1;
          pf_cancel = !pf_ready;
        end
      end
      S_PEND: begin
        if (pf_ready) begin
          pf_flush = 1'b1;
        end else if (override) begin
          pf_cancel = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Front-end flush only for MEM-stage commits; ID handles its own branch shadow.
  assign front_flush = ex_req | eret_req;

  assign rd_pending = (state == S_PEND);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: expectations queued with stimulus, drained on output.
module tb_pc_redirect_ctrl;

  localparam int SEL_PC   = 0;
  localparam int SEL_PEND = 1;
  localparam int SEL_FF   = 2;
  localparam int SEL_PFF  = 3;
  localparam int SEL_CAN  = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        pc_wr;
  logic        pf_ready;
  logic        br_req;
  logic [31:0] br_target;
  logic        eret_req;
  logic [31:0] epc;
  logic        ex_req;
  logic [31:0] pf_pc;
  logic        front_flush;
  logic        pf_flush;
  logic        pf_cancel;
  logic        rd_pending;

  exp_t q_now[$];
  exp_t q_next[$];
  int   n_cmp;
  int   n_err;

  pc_redirect_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .pc_wr       (pc_wr),
    .pf_ready    (pf_ready),
    .br_req      (br_req),
    .br_target   (br_target),
    .eret_req    (eret_req),
    .epc         (epc),
    .ex_req      (ex_req),
    .pf_pc       (pf_pc),
    .front_flush (front_flush),
    .pf_flush    (pf_flush),
    .pf_cancel   (pf_cancel),
    .rd_pending  (rd_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      SEL_PC:   return pf_pc;
      SEL_PEND: return {31'd0, rd_pending};
      SEL_FF:   return {31'd0, front_flush};
      SEL_PFF:  return {31'd0, pf_flush};
      default:  return {31'd0, pf_cancel};
    endcase
  endfunction

  task automatic drain_now();
    exp_t e;
    while (q_now.size() > 0) begin
      e = q_now.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic drain_next();
    exp_t e;
    while (q_next.size() > 0) begin
      e = q_next.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
  endtask

  // One clock of stimulus, entered and left at a falling edge. -1 marks a don't-care strobe.
  task automatic cyc(input string tag, input logic wr, input logic rdy,
                     input logic br, input logic [31:0] bt,
                     input logic er, input logic [31:0] ep, input logic ex,
                     input int e_ff, input int e_pff, input int e_can,
                     input logic [31:0] e_pc, input int e_pend);
    pc_wr     = wr;
    pf_ready  = rdy;
    br_req    = br;
    br_target = bt;
    eret_req  = er;
    epc       = ep;
    ex_req    = ex;
    if (e_ff  >= 0) q_now.push_back('{{tag, ".front_flush"}, SEL_FF,  32'(e_ff)});
    if (e_pff >= 0) q_now.push_back('{{tag, ".pf_flush"},    SEL_PFF, 32'(e_pff)});
    if (e_can >= 0) q_now.push_back('{{tag, ".pf_cancel"},   SEL_CAN, 32'(e_can)});
    q_next.push_back('{{tag, ".pf_pc"}, SEL_PC, e_pc});
    if (e_pend >= 0) q_next.push_back('{{tag, ".rd_pending"}, SEL_PEND, 32'(e_pend)});
    #1;
    drain_now();
    @(posedge clk);
    #1;
    drain_next();
    @(negedge clk);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    pc_wr     = 1'b0;
    pf_ready  = 1'b0;
    br_req    = 1'b0;
    br_target = '0;
    eret_req  = 1'b0;
    epc       = '0;
    ex_req    = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.pf_pc", pf_pc, 32'hBFC0_0000);
    chk("reset.rd_pending", {31'd0, rd_pending}, 32'd0);
    chk("reset.pf_flush", {31'd0, pf_flush}, 32'd0);
    chk("reset.pf_cancel", {31'd0, pf_cancel}, 32'd0);
    rst = 1'b0;

    // Sequential advance
    cyc("seq1", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0004, 0);
    cyc("seq2", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0008, 0);
    cyc("seq3", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_000C, 0);
    cyc("seq4", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0010, 0);

    // Branch taken with fetch ready
    cyc("br", 1, 1, 1, 32'hBFC0_0100, 0, 0, 0, 0, 1, 0, 32'hBFC0_0100, 0);

    // Branch held, overridden by exception, issued later
    cyc("br_hold", 1, 0, 1, 32'hBFC0_0200, 0, 0, 0, 0, 1, 1, 32'hBFC0_0100, 1);
    cyc("ex_ovr",  1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'hBFC0_0100, 1);
    cyc("wait",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0100, 1);
    cyc("issue",   1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'hBFC0_0380, 0);

    // Exception held; later branch is lower priority and ignored
    cyc("ex_hold",  1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 32'hBFC0_0380, 1);
    cyc("br_under", 1, 0, 1, 32'hBFC0_0400, 0, 0, 0, 0, 0, 0, 32'hBFC0_0380, 1);
    cyc("issue_ex", 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'hBFC0_0380, 0);
    cyc("seq_ex",   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0384, 0);

    // Equal-priority tie at issue keeps the older pending target
    cyc("br_hold2", 0, 0, 1, 32'hBFC0_0500, 0, 0, 0, 0, 1, 1, 32'hBFC0_0384, 1);
    cyc("br_tie",   0, 1, 1, 32'hBFC0_0600, 0, 0, 0, 0, 1, 0, 32'hBFC0_0500, 0);

    // Simultaneous exception and ERET
    cyc("ex_eret", 1, 1, 0, 0, 1, 32'h8000_1234, 1, 1, 1, 0, 32'hBFC0_0380, 0);
    cyc("post_ex", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0380, 0);

    // Wraparound and ERET under stall
    cyc("br_top",    1, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0);
    cyc("wrap",      1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0);
    cyc("eret_nowr", 0, 1, 0, 0, 1, 32'h8000_0040, 0, 1, 1, 0, 32'h8000_0040, 0);
    cyc("stall_rdy", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0040, 0);

    // Reset while a redirect is pending
    cyc("br_pend7", 1, 0, 1, 32'hBFC0_0700, 0, 0, 0, 0, 1, 1, 32'h8000_0040, 1);
    br_req = 1'b0;
    rst    = 1'b1;
    #1;
    chk("rst_mid.pf_pc", pf_pc, 32'hBFC0_0000);
    chk("rst_mid.rd_pending", {31'd0, rd_pending}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("post_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0004, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
